present_ctr_ctrl: RTL and testbench
===================================

# present_ctr_ctrl

Counter-mode (CTR) sequencer for the PRESENT-128 encryption core. It wraps the iterative encrypt stage on both sides: it builds counter blocks, pulses the core's `load`, and waits for `done`. It then XORs the resulting keystream with plaintext beats taken from a valid/ready stream and presents the ciphertext on an output stream. Decryption is the same operation.

## Interface
Parameters:
- `CTR_W`, default 32: counter width in bits; nonce width is `64-CTR_W`; legal range 8..56.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  opens a session when `busy`=0; ignored otherwise.
- `key`  in  128  session key, captured on accepted `start`.
- `nonce`  in  64-CTR_W  session nonce, captured on accepted `start`.
- `ctr_init`  in  CTR_W  initial counter, captured on accepted `start`.
- `s_valid` / `s_ready` / `s_data[63:0]` / `s_last`  in/out/in/in  plaintext stream.
- `m_valid` / `m_ready` / `m_data[63:0]` / `m_last`  out/in/out/out  ciphertext stream.
- `core_load`  out  1  one-cycle load strobe to the encrypt core.
- `core_in_data`  out  64  counter block `{nonce_reg, ctr_reg}`.
- `core_key`  out  128  `key_reg`.
- `core_out_data`  in  64  core result.
- `core_done`  in  1  core completion flag; level, cleared by the core on `core_load`.
- `busy`  out  1  `state!=IDLE || m_valid`.
- `err_wrap`  out  1  sticky; set when the counter wraps. Cleared on accepted `start`.

## Operation
- FSM states: IDLE, LOAD, WAIT, ARMED. Registers: `key_reg`, `nonce_reg`, `ctr_reg`, `ks_reg[63:0]`, output register (`m_data`, `m_last`, `m_valid`).
- IDLE: `start && !busy` captures `key`, `nonce`, `ctr_init`, clears `err_wrap`, and moves to LOAD.
- LOAD: `core_load`=1 for exactly one cycle, then WAIT. `core_in_data` and `core_key` are stable from LOAD through the end of WAIT.
- WAIT: `core_done` is sampled every cycle. On `core_done`=1, `ks_reg <= core_out_data` and the FSM moves to ARMED. A stale `core_done` from the previous block cannot be seen, because the core clears it on the edge that samples `core_load`.
- ARMED: `s_ready = !m_valid` (no combinational path from `m_ready`).
  - On the `s_valid && s_ready` handshake: `m_data <= s_data ^ ks_reg`, `m_last <= s_last`, `m_valid <= 1`, `ctr_reg <= ctr_reg + 1` (mod 2^CTR_W).
  - After the handshake, the FSM goes to LOAD if `s_last`=0, else to IDLE.
- Keystream is pre-fetched: block N+1 encrypts while ciphertext N waits in the output register.
- Output: `m_valid` clears on `m_valid && m_ready`. `m_data` and `m_last` hold while `m_valid && !m_ready`.
- Counter wrap: an increment from all-ones to 0 sets `err_wrap`. Operation continues with counter 0; no stall.
- `s_ready`=0 in IDLE, LOAD and WAIT. Beats offered there are not consumed.
- `start` with `busy`=1 is ignored and has no effect.

## Timing
- Reset values: `state`=IDLE, `m_valid`=0, `m_data`=0, `m_last`=0, `core_load`=0, `err_wrap`=0, `ks_reg`=0, `ctr_reg`=0, `key_reg`=0, `nonce_reg`=0; hence `s_ready`=0, `busy`=0.
- Reset mid-session: everything returns to the above. An in-flight core operation is abandoned, and the core's next `load` restarts it.
- `start` at edge T: `core_load`=1 during cycle T+1. The core accepts it at edge T+2.
- Core latency of L cycles after its load edge: `core_done` is seen at edge T+2+L and ARMED begins at cycle T+3+L. For the 5-round core, L=5, so ARMED begins 8 cycles after `start`.
- Plaintext-to-ciphertext latency: `m_valid` rises 1 cycle after the input handshake.
- Steady-state throughput: one beat per L+3 cycles (LOAD + WAIT + ARMED), assuming `m_ready`=1.
- Any L ≥ 1 is tolerated. There is no timeout.

## Test plan
- Core stubbed as `out = in ^ 64'hA5A5_A5A5_A5A5_A5A5`, done 5 cycles after load. `start` with `nonce=32'h0000_0001`, `ctr_init=32'h0`, then one beat `s_data=64'h0`, `s_last=1`. Required: `m_data=64'hA5A5_A5A4_A5A5_A5A5`, `m_last=1`, `core_load` high in cycle 1 only, `busy` drops after the `m_ready` handshake.
- Three-beat message with `m_ready`=1. Required: `core_in_data` counter fields 0, 1, 2; exactly 3 `core_load` pulses; `s_ready` never high while `m_valid`=1.
- Backpressure: `m_ready`=0 for 20 cycles on beat 0. Required: `m_data` stable, `s_ready`=0, and the next keystream is already in `ks_reg` (state ARMED). Beat 1 is accepted the cycle after `m_ready` pulses.
- `ctr_init=32'hFFFF_FFFF`, two beats. Required: second counter block has counter field 0, `err_wrap`=1. A following `start` clears `err_wrap`.
- Assert `rst` during WAIT. Required: all outputs at reset values immediately (asynchronous). A new `start` afterwards produces correct data. A `start` pulsed while `busy`=1 changes nothing.
- Stub core with `done` latency of 1 and of 31 cycles. Required: same ciphertext values, with throughput of L+3 cycles per beat.

Source files
------------

// File: rtl/present_ctr_ctrl.sv
// present_ctr_ctrl: CTR-mode sequencer around an iterative PRESENT-128 core.
// Builds counter blocks, strobes the core, and XORs the keystream into a valid/ready stream.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, key, nonce,       session open (accepted only when !busy)
//   ctr_init
//   s_valid/s_ready/s_data/  plaintext input stream
//   s_last
//   m_valid/m_ready/m_data/  ciphertext output stream (registered)
//   m_last
//   core_load, core_in_data, encrypt core request side
//   core_key
//   core_out_data, core_done encrypt core result side
//   busy, err_wrap           session active / sticky counter-wrap flag
module present_ctr_ctrl #(
  parameter int CTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [127:0]       key,
  input  logic [63-CTR_W:0]  nonce,
  input  logic [CTR_W-1:0]   ctr_init,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [63:0]        s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [63:0]        m_data,
  output logic               m_last,
  output logic               core_load,
  output logic [63:0]        core_in_data,
  output logic [127:0]       core_key,
  input  logic [63:0]        core_out_data,
  input  logic               core_done,
  output logic               busy,
  output logic               err_wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    ARMED = 2'd3
  } state_t;

  localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nx;
  logic [127:0]        key_reg;
  logic [63-CTR_W:0]   nonce_reg;
  logic [CTR_W-1:0]    ctr_reg;
  logic [63:0]         ks_reg;
  logic                start_ok;
  logic                s_hs;

  assign busy         = (state != IDLE) || m_valid;
  assign start_ok     = (state == IDLE) && start && !m_valid;
  // Only one beat may be held in the output register; the next
  // keystream block is fetched while that beat waits for m_ready.
  assign s_ready      = (state == ARMED) && !m_valid;
  assign s_hs         = s_ready && s_valid;
  assign core_load    = (state == LOAD);
  assign core_in_data = {nonce_reg, ctr_reg};
  assign core_key     = key_reg;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok) state_nx = LOAD;
      LOAD:    state_nx = WAIT;
      WAIT:    if (core_done) state_nx = ARMED;
      ARMED:   if (s_hs) state_nx = s_last ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg   <= '0;
      nonce_reg <= '0;
      ctr_reg   <= '0;
      ks_reg    <= '0;
      err_wrap  <= 1'b0;
    end else begin
      if (start_ok) begin
        key_reg   <= key;
        nonce_reg <= nonce;
        ctr_reg   <= ctr_init;
        err_wrap  <= 1'b0;
      end
      if (state == WAIT && core_done) begin
        ks_reg <= core_out_data;
      end
      if (s_hs) begin
        ctr_reg <= ctr_reg + CTR_ONE;
        // Wrap is flagged but not stalled on.
        if (&ctr_reg) begin
          err_wrap <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      if (s_hs) begin
        m_valid <= 1'b1;
        m_data  <= s_data ^ ks_reg;
        m_last  <= s_last;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_present_ctr_ctrl.sv
// tb_present_ctr_ctrl: directed bench for present_ctr_ctrl with a stub core.
// Stub core: out = in ^ A5 pattern, done raised lat cycles after load.
module tb_present_ctr_ctrl;

  localparam logic [63:0] PAD = 64'hA5A5_A5A5_A5A5_A5A5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [31:0]  nonce = '0;
  logic [31:0]  ctr_init = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [63:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [63:0]  m_data;
  logic         m_last;
  logic         core_load;
  logic [63:0]  core_in_data;
  logic [127:0] core_key;
  logic [63:0]  core_out_data;
  logic         core_done = 1'b0;
  logic         busy;
  logic         err_wrap;

  always #5 clk = ~clk;

  present_ctr_ctrl #(.CTR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .nonce(nonce), .ctr_init(ctr_init),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last),
    .core_load(core_load), .core_in_data(core_in_data),
    .core_key(core_key), .core_out_data(core_out_data),
    .core_done(core_done), .busy(busy), .err_wrap(err_wrap)
  );

  int          lat = 5;
  int          cnt = 0;
  logic [63:0] cin = '0;

  always @(posedge clk) begin
    if (core_load) begin
      cnt       <= lat;
      core_done <= 1'b0;
      cin       <= core_in_data;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) core_done <= 1'b1;
    end
  end
  assign core_out_data = cin ^ PAD;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        last;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          load_cyc[$];
  logic [31:0] ctr_q[$];
  logic [31:0] nonce_m;
  logic [31:0] ctr_m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (core_load) begin
        load_cyc.push_back(cyc);
        ctr_q.push_back(core_in_data[31:0]);
      end
      if (m_valid) check("s_ready_excl", s_ready, 0);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("sb_extra", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
        end
      end
    end
  end

  task automatic start_session(input logic [127:0] k,
                               input logic [31:0] n,
                               input logic [31:0] c);
    nonce_m  = n;
    ctr_m    = c;
    key      = k;
    nonce    = n;
    ctr_init = c;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push_exp(input logic [63:0] d, input logic l);
    exp_t e;
    e.data = d ^ {nonce_m, ctr_m} ^ PAD;
    e.last = l;
    sb.push_back(e);
    ctr_m = ctr_m + 32'd1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int n;
    push_exp(d, l);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s_hs_timeout", n < 200, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 200, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic clear_mon();
    load_cyc.delete();
    ctr_q.delete();
  endtask

  initial begin
    logic [63:0] exp0;
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_core_load", core_load, 0);
    check("rst_err_wrap", err_wrap, 0);
    check("rst_m_data", m_data, 0);
    check("rst_core_in", core_in_data, 0);
    check("rst_core_key", core_key, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single beat, known-answer
    clear_mon();
    start_session(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                  32'h0000_0001, 32'h0);
    @(negedge clk);
    check("t1_load_hi", core_load, 1);
    check("t1_core_in", core_in_data, 64'h0000_0001_0000_0000);
    check("t1_core_key", core_key,
          128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    @(negedge clk);
    check("t1_load_lo", core_load, 0);
    send_beat(64'h0, 1'b1);
    wait_idle();
    check("t1_ct", m_data, 64'hA5A5_A5A4_A5A5_A5A5);
    check("t1_last", m_last, 1);
    check("t1_nloads", load_cyc.size(), 1);

    // three beats, free-flowing output
    clear_mon();
    start_session({4{$urandom}}, 32'h1234_5678, 32'h0);
    send_beat({$urandom, $urandom}, 1'b0);
    send_beat({$urandom, $urandom}, 1'b0);
    send_beat({$urandom, $urandom}, 1'b1);
    wait_idle();
    check("t2_nloads", load_cyc.size(), 3);
    check("t2_ctr0", ctr_q[0], 0);
    check("t2_ctr1", ctr_q[1], 1);
    check("t2_ctr2", ctr_q[2], 2);

    // backpressure on beat 0
    m_ready = 1'b0;
    start_session({4{$urandom}}, 32'h0000_CAFE, 32'd10);
    exp0 = 64'h1111_2222_3333_4444 ^ {32'h0000_CAFE, 32'd10} ^ PAD;
    send_beat(64'h1111_2222_3333_4444, 1'b0);
    push_exp(64'h5555_6666_7777_8888, 1'b1);
    s_data  = 64'h5555_6666_7777_8888;
    s_last  = 1'b1;
    s_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("t3_s_ready", s_ready, 0);
      check("t3_hold", m_data, exp0);
    end
    check("t3_ks", dut.ks_reg, {32'h0000_CAFE, 32'd11} ^ PAD);
    check("t3_armed", dut.state, 2'd3);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    check("t3_accept", s_ready, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    check("t3_mv", m_valid, 1);
    m_ready = 1'b1;
    wait_idle();

    // counter wrap
    clear_mon();
    start_session({4{$urandom}}, 32'h0000_0007, 32'hFFFF_FFFF);
    send_beat({$urandom, $urandom}, 1'b0);
    send_beat({$urandom, $urandom}, 1'b1);
    wait_idle();
    check("t4_ctr0", ctr_q[0], 32'hFFFF_FFFF);
    check("t4_ctr1", ctr_q[1], 0);
    check("t4_wrap", err_wrap, 1);
    start_session({4{$urandom}}, 32'h0000_0008, 32'd3);
    check("t4_wrap_clr", err_wrap, 0);
    send_beat({$urandom, $urandom}, 1'b1);
    wait_idle();

    // async reset during WAIT
    start_session({4{$urandom}}, 32'h0000_0009, 32'd20);
    @(negedge clk);
    @(negedge clk);
    check("t5_in_wait", dut.state, 2'd2);
    #1 rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_load", core_load, 0);
    check("t5_s_ready", s_ready, 0);
    check("t5_m_valid", m_valid, 0);
    check("t5_m_data", m_data, 0);
    check("t5_m_last", m_last, 0);
    check("t5_core_in", core_in_data, 0);
    check("t5_core_key", core_key, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    start_session({4{$urandom}}, 32'h0000_0055, 32'd100);
    nonce    = 32'hDEAD_BEEF;
    ctr_init = 32'd999;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("t5_ign_start", core_in_data, {32'h0000_0055, 32'd100});
    send_beat({$urandom, $urandom}, 1'b1);
    wait_idle();
    check("t5_nloads", load_cyc.size(), 1);

    // core latency 1 and 31
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 31;
      clear_mon();
      start_session({4{$urandom}}, $urandom, $urandom);
      send_beat({$urandom, $urandom}, 1'b0);
      send_beat({$urandom, $urandom}, 1'b0);
      send_beat({$urandom, $urandom}, 1'b1);
      wait_idle();
      check("t6_nloads", load_cyc.size(), 3);
      check("t6_rate0", load_cyc[1] - load_cyc[0], lat + 3);
      check("t6_rate1", load_cyc[2] - load_cyc[1], lat + 3);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
